// File: rtl/tile_line_fetcher_if.sv
// SRAM read bus and pixel stream of the tile line fetcher.
// master: the fetcher (drives address/enables and the pixel stream).
// slave:  the SRAM plus pixel FIFO side.
interface tile_line_fetcher_if #(
  parameter int unsigned ADDR_W = 18
) ();

  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_din;
  logic              ram_ce;
  logic              ram_oe;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_pixel;

  modport master (
    output ram_addr, ram_ce, ram_oe, out_valid, out_pixel,
    input  ram_din, out_ready
  );

  modport slave (
    input  ram_addr, ram_ce, ram_oe, out_valid, out_pixel,
    output ram_din, out_ready
  );

endinterface

// File: rtl/tile_line_fetcher.sv
// Background line fetcher: walks one character-map row per scanline, fetches the
// 4bpp pattern row of each tile and streams {palette, index} pixels downstream.
// Optional macro FLIP_EN enables per-character horizontal/vertical flip
// (char word bits 13/14); without it those bits are ignored.
module tile_line_fetcher #(
  parameter int unsigned       ADDR_W        = 18,
  parameter int unsigned       COLS          = 40,
  parameter int unsigned       MAP_ROW_SHIFT = 6,
  parameter logic [ADDR_W-1:0] MAP_BASE      = '0,
  parameter logic [ADDR_W-1:0] TILE_BASE     = ADDR_W'(18'h10000)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lineStart,
  input  logic [9:0]           vPos,
  input  logic [9:0]           hScroll,
  output logic                 busy,
  output logic                 lineDone,
  tile_line_fetcher_if.master  bus
);

  // Wide enough for column indices 0..COLS (the extra fine-scroll column).
  localparam int unsigned ColW = $clog2(COLS + 2);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StChar  = 3'd1;
  localparam logic [2:0] StWord0 = 3'd2;
  localparam logic [2:0] StWord1 = 3'd3;
  localparam logic [2:0] StEmit  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [9:0]        vpos_q, vpos_d;
  logic [9:0]        hscroll_q, hscroll_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [3:0]        pal_q, pal_d;
  logic              hflip_q, hflip_d;
  logic [15:0]       word0_q, word0_d;
  logic [15:0]       word1_q, word1_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        end_q, end_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              din_hflip;
  logic              din_vflip;
  logic              unused_din;

`ifdef FLIP_EN
  assign din_hflip  = bus.ram_din[13];
  assign din_vflip  = bus.ram_din[14];
  assign unused_din = bus.ram_din[15];
`else
  assign din_hflip  = 1'b0;
  assign din_vflip  = 1'b0;
  assign unused_din = ^bus.ram_din[15:13];
`endif

  // Map entry address; column index wraps inside the map row.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [9:0]      vp,
                                                 input logic [9:0]      hs,
                                                 input logic [ColW-1:0] col);
    logic [31:0] csum;
    csum = 32'(hs[9:3]) + 32'(col);
    csum = csum & ((32'd1 << MAP_ROW_SHIFT) - 32'd1);
    return MAP_BASE + (ADDR_W'(vp[9:3]) << MAP_ROW_SHIFT) + ADDR_W'(csum);
  endfunction

  // Word0 address of one pattern row: 16 words per tile, 2 per row.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [8:0] tile,
                                                  input logic [2:0] row);
    return TILE_BASE + ADDR_W'({tile, 4'b0000}) + ADDR_W'({row, 1'b0});
  endfunction

  logic [2:0]      fine_x;
  logic [ColW-1:0] last_col;
  logic [2:0]      phys_px;
  logic [31:0]     pat_shift;

  assign fine_x   = hscroll_q[2:0];
  // A non-zero fine scroll adds one partial column at the end of the line.
  assign last_col = (fine_x != 3'd0) ? ColW'(COLS) : ColW'(COLS - 1);

  // Pointer is the screen position within the character; hflip mirrors it.
  assign phys_px   = hflip_q ? ~ptr_q : ptr_q;
  assign pat_shift = {word0_q, word1_q} << {phys_px, 2'b00};

  // Outputs come straight from registers; no path from out_ready.
  always_comb begin
    bus.ram_addr  = addr_q;
    bus.ram_ce    = busy_q;
    bus.ram_oe    = busy_q;
    bus.out_valid = (state_q == StEmit);
    bus.out_pixel = (state_q == StEmit) ? {pal_q, pat_shift[31:28]} : 8'h00;
    busy          = busy_q;
    lineDone      = done_q;
  end

  // Fetch sequencing: map entry, two pattern words, then pixel emission.
  always_comb begin
    state_d   = state_q;
    vpos_d    = vpos_q;
    hscroll_d = hscroll_q;
    col_d     = col_q;
    pal_d     = pal_q;
    hflip_d   = hflip_q;
    word0_d   = word0_q;
    word1_d   = word1_q;
    ptr_d     = ptr_q;
    end_d     = end_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (lineStart) begin
          vpos_d    = vPos;
          hscroll_d = hScroll;
          col_d     = '0;
          addr_d    = map_addr(vPos, hScroll, '0);
          busy_d    = 1'b1;
          state_d   = StChar;
        end
      end
      StChar: begin
        pal_d   = bus.ram_din[12:9];
        hflip_d = din_hflip;
        addr_d  = tile_addr(bus.ram_din[8:0], din_vflip ? ~vpos_q[2:0] : vpos_q[2:0]);
        state_d = StWord0;
      end
      StWord0: begin
        word0_d = bus.ram_din;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = StWord1;
      end
      StWord1: begin
        word1_d = bus.ram_din;
        // First column starts at the fine offset; the extra column stops before it.
        ptr_d   = (col_q == '0) ? fine_x : 3'd0;
        end_d   = ((fine_x != 3'd0) && (col_q == ColW'(COLS))) ? fine_x - 3'd1 : 3'd7;
        state_d = StEmit;
      end
      StEmit: begin
        if (bus.out_ready) begin
          if (ptr_q == end_q) begin
            if (col_q != last_col) begin
              col_d   = col_q + ColW'(1);
              addr_d  = map_addr(vpos_q, hscroll_q, col_q + ColW'(1));
              state_d = StChar;
            end else begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              addr_d  = '0;
              state_d = StIdle;
            end
          end else begin
            ptr_d = ptr_q + 3'd1;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any line in progress without lineDone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      vpos_q    <= '0;
      hscroll_q <= '0;
      col_q     <= '0;
      pal_q     <= '0;
      hflip_q   <= 1'b0;
      word0_q   <= '0;
      word1_q   <= '0;
      ptr_q     <= '0;
      end_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vpos_q    <= vpos_d;
      hscroll_q <= hscroll_d;
      col_q     <= col_d;
      pal_q     <= pal_d;
      hflip_q   <= hflip_d;
      word0_q   <= word0_d;
      word1_q   <= word1_d;
      ptr_q     <= ptr_d;
      end_q     <= end_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule
